// File: rtl/lcd_sp_receiver_if.sv
// LCD serial-link receiver bus: serial input, FIFO read side and status.
// master = the side driving CS/SI/rd_en/clr_err; slave = the receiver.
interface lcd_sp_receiver_if #(
  parameter int PTR_W = 2
);
  logic             CS;
  logic             SI;
  logic             rd_en;
  logic             clr_err;
  logic [7:0]       data_out;
  logic             empty;
  logic             full;
  logic [PTR_W:0]   level;
  logic             byte_valid;
  logic             frame_err;
  logic             overflow;
  logic [15:0]      byte_count;

  modport master (
    output CS, SI, rd_en, clr_err,
    input  data_out, empty, full, level, byte_valid, frame_err, overflow, byte_count
  );

  modport slave (
    input  CS, SI, rd_en, clr_err,
    output data_out, empty, full, level, byte_valid, frame_err, overflow, byte_count
  );
endinterface

// File: rtl/lcd_sp_receiver.sv
// Serial-to-parallel receiver for the LCD serial link.
// Samples SI every clock while CS is low, assembles MSB-first bytes and
// queues them in a first-word-fall-through FIFO. Flags framing errors
// (CS rising mid-byte) and sticky overflow (byte dropped while full).
// Optional macro LCD_RX_BYTE_COUNT_EN builds a 16-bit accepted-byte counter;
// without it byte_count is tied to zero.
module lcd_sp_receiver #(
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = 2
) (
  input logic                clock,
  input logic                reset,
  lcd_sp_receiver_if.slave   bus
);

  localparam logic [PTR_W:0] DEPTH_L = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_q;
  logic             fe_q;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   level_q;
  logic [7:0]       dout_q;
  logic             bv_q;
  logic             ovf_q;

  logic [7:0]       byte_in;
  logic             byte_done;
  logic             do_rd;
  logic             accept;
  logic             drop;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [PTR_W:0]   level_nxt;
  logic [7:0]       head_nxt;

  // Byte completion and FIFO next-state: a byte is taken when there is room,
  // or when a read frees a slot in the same cycle.
  always_comb begin
    byte_in    = {shift_q[6:0], bus.SI};
    byte_done  = !bus.CS && (state == SHIFT) && (bit_cnt == 3'd7);
    do_rd      = bus.rd_en && (level_q != '0);
    accept     = byte_done && ((level_q != DEPTH_L) || do_rd);
    drop       = byte_done && !accept;
    rd_ptr_nxt = do_rd ? rd_ptr + PTR_W'(1) : rd_ptr;
    level_nxt  = level_q + (PTR_W+1)'(accept) - (PTR_W+1)'(do_rd);
    // The incoming byte becomes the head when it lands in the slot the read
    // pointer will point at (FIFO empty, or last entry popped this cycle).
    head_nxt   = (accept && (wr_ptr == rd_ptr_nxt)) ? byte_in : mem[rd_ptr_nxt];
  end

  // Frame FSM: IDLE waits for CS low, SHIFT assembles bits back-to-back.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= 3'd0;
      shift_q <= 8'd0;
      fe_q    <= 1'b0;
    end else begin
      fe_q <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.CS) begin
            shift_q <= {7'd0, bus.SI};
            bit_cnt <= 3'd1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (!bus.CS) begin
            shift_q <= byte_in;
            bit_cnt <= bit_cnt + 3'd1;
          end else begin
            if (bit_cnt != 3'd0) begin
              fe_q <= 1'b1;
            end
            shift_q <= 8'd0;
            bit_cnt <= 3'd0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO storage; contents are only visible through the pointers, so no reset.
  always_ff @(posedge clock) begin
    if (accept) begin
      mem[wr_ptr] <= byte_in;
    end
  end

  // FIFO pointers, level, registered head and status flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      dout_q  <= 8'd0;
      bv_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      rd_ptr  <= rd_ptr_nxt;
      level_q <= level_nxt;
      // Head holds its last value once the FIFO drains.
      if (level_nxt != '0) begin
        dout_q <= head_nxt;
      end
      bv_q <= accept;
      // A new drop outranks a simultaneous clear.
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (bus.clr_err) begin
        ovf_q <= 1'b0;
      end
    end
  end

`ifdef LCD_RX_BYTE_COUNT_EN
  logic [15:0] cnt_q;

  // Accepted-byte counter, wraps at 16 bits, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= 16'd0;
    end else if (accept) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign bus.byte_count = cnt_q;
`else
  assign bus.byte_count = 16'd0;
`endif

  assign bus.data_out   = dout_q;
  assign bus.empty      = (level_q == '0);
  assign bus.full       = (level_q == DEPTH_L);
  assign bus.level      = level_q;
  assign bus.byte_valid = bv_q;
  assign bus.frame_err  = fe_q;
  assign bus.overflow   = ovf_q;

endmodule

// File: doc/lcd_sp_receiver.md
Name: lcd_sp_receiver

Overview:
Serial-to-parallel receiver for the LCD serial link: the far end of the 8-bit parallel-to-serial LCD converter. Samples SI on every clock while CS is low, assembles MSB-first bytes, and buffers complete bytes in a small first-word-fall-through FIFO. Used as an LCD-link monitor and loopback checker and as the front end for a byte-level command decoder. Reports framing errors and overflow.

Parameters:
FIFO_DEPTH, 4, number of byte entries in the receive FIFO; power of two, minimum 2.
PTR_W, 2, log2(FIFO_DEPTH), the FIFO pointer width.

Ports:
clock  input  1  system clock; all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
CS  input  1  chip select, active low; a frame is active while 0.
SI  input  1  serial data; one bit per clock while CS=0, MSB first.
rd_en  input  1  pop the head FIFO entry; ignored when empty=1.
clr_err  input  1  clears the sticky overflow flag.
data_out  output  8  head FIFO entry (FWFT); holds the last value when empty.
empty  output  1  FIFO holds no entries.
full  output  1  FIFO holds FIFO_DEPTH entries.
level  output  PTR_W+1  number of entries in the FIFO.
byte_valid  output  1  1-cycle pulse when a byte is written into the FIFO.
frame_err  output  1  1-cycle pulse when CS rises mid-byte.
overflow  output  1  sticky; set when a completed byte is dropped because the FIFO is full.
byte_count  output  16  bytes accepted (see Optional Feature).

Behaviour:
- Reset values:
  - data_out=0, empty=1, full=0, level=0.
  - byte_valid=0, frame_err=0, overflow=0, byte_count=0.
  - bit_cnt=0, shift register=0, state=IDLE, pointers=0.
- FSM with two states:
  - IDLE: while CS=1, no sampling. When CS=0 is sampled, SI in that same cycle is bit 7; bit_cnt=1; go to SHIFT.
  - SHIFT, CS=0: shift = {shift[6:0], SI}; bit_cnt increments.
  - SHIFT, 8th bit sampled (bit_cnt 7 -> 0): the assembled byte goes to the FIFO write path. Stay in SHIFT; the next CS=0 cycle is bit 7 of the next byte (back-to-back bytes, no gap).
  - SHIFT, CS=1 with bit_cnt=0 (byte boundary): clean end of frame; go to IDLE, no error.
  - SHIFT, CS=1 with bit_cnt 1..7: discard the partial byte; pulse frame_err for 1 cycle; go to IDLE. Nothing is written.
- Write latency: the byte is in the FIFO, and byte_valid=1, in the cycle after its 8th bit is sampled. When empty was 1 before the write, data_out shows the byte in that same cycle.
- FIFO:
  - Read side is FWFT: data_out = mem[rd_ptr]; rd_en advances rd_ptr at the edge.
  - Pointers wrap modulo FIFO_DEPTH.
  - level = wr_count - rd_count, range 0..FIFO_DEPTH.
- Boundary cases:
  - Write while full and no read: byte dropped; overflow set; byte_valid stays 0; byte_count unchanged.
  - Write while full with rd_en=1: read and write both occur; level unchanged; no overflow.
  - rd_en while empty: ignored. A simultaneous write proceeds normally.
  - clr_err and a new overflow in the same cycle: overflow stays 1 (set wins).
- reset=1 mid-frame: everything returns to reset values and the partial byte is discarded. After reset is released, a frame is only recognised on CS=0. If CS is still low, the receiver starts at bit 7 on the first sampled cycle.

Optional Feature:
LCD_RX_BYTE_COUNT_EN
- Defined: byte_count is a 16-bit counter. It increments on every byte_valid pulse, wraps 65535 -> 0, and clears only on reset.
- Undefined: the counter is not built and byte_count is tied to 0. All other behaviour is identical.

Test Plan:
1. Single byte: reset, then CS=0 for 8 cycles with SI=1,0,1,0,0,1,0,1, then CS=1. Expect byte_valid pulse, data_out=0xA5, level=1, empty=0, frame_err=0. Then rd_en=1 -> empty=1, level=0.
2. Back-to-back bytes: CS low for 24 cycles carrying 0x3C, 0xFF, 0x00. Expect 3 byte_valid pulses, each 8 cycles apart. FIFO pops in order 0x3C, 0xFF, 0x00.
3. Framing error: CS low for 5 bits, then CS=1. Expect a frame_err pulse, level unchanged, no byte_valid. A following full byte 0x81 is received correctly.
4. Overflow: send 5 bytes 0x01..0x05 with no reads (FIFO_DEPTH=4). Expect full=1, overflow=1 after byte 5, FIFO contents 0x01..0x04. clr_err -> overflow=0.
5. Simultaneous read and write at full: FIFO full, 6th byte completes with rd_en=1 in the write cycle. Expect level=4, no overflow, head advances to 0x02, tail holds the new byte.
6. Reset mid-byte: assert reset after 3 bits. Expect all outputs at reset values. Then CS=1, followed by a byte 0x5A -> data_out=0x5A. With LCD_RX_BYTE_COUNT_EN: byte_count=1.
